// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture_pkg
//  Purpose  : Shared constants for the pwm_capture pulse-measurement block:
//             default counter width, saturation value and FSM state codes.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    // Default counter width; matches the synthesiser period width.
    localparam int c_CTR_SIZE_DEFAULT = 24;

    // Saturation value of a default-width cycle counter.
    localparam logic [c_CTR_SIZE_DEFAULT-1:0] c_CNT_MAX = '1;

    // Measurement FSM encoding.
    localparam int       c_STATE_W = 1;
    localparam logic [0:0] c_ST_ARM  = 1'b0;   // waiting for the first rising edge
    localparam logic [0:0] c_ST_RUN  = 1'b1;   // measuring

endpackage : pwm_capture_pkg
`default_nettype wire

// File: rtl/pwm_capture_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : edge_sync
//  Purpose  : Two-flop synchroniser for an asynchronous input followed by a
//             single-cycle rising/falling edge detector. Suitable for any slow
//             external input (pulse pins, buttons).
//  Ports    : clk     - system clock
//             rst     - synchronous active-high reset
//             i_in    - asynchronous input
//             o_level - synchronised input level
//             o_rise  - one-cycle pulse on a synchronised 0->1 transition
//             o_fall  - one-cycle pulse on a synchronised 1->0 transition
//  Revision : 1.0 - initial release
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s0;
    logic r_s1;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s0   <= i_in;
            r_s1   <= r_s0;
            r_prev <= r_s1;
        end
    end

    // Every edge sees the same pipeline delay, so intervals between edges
    // are preserved exactly.
    assign o_level = r_s1;
    assign o_rise  = r_s1 & ~r_prev;
    assign o_fall  = ~r_s1 & r_prev;

endmodule : edge_sync
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures an incoming pulse waveform. Reports the period and the
//             high time (in clk cycles) of every complete cycle, with a
//             one-cycle strobe per measurement, and flags a stalled/constant
//             input when no rising edge arrives before the counter saturates.
//  Ports    : clk         - system clock
//             rst         - synchronous active-high reset
//             pwm_in      - asynchronous pulse input
//             period      - cycles between the last two rising edges
//             high_time   - cycles from a rising edge to the following fall
//             new_measure - one-cycle strobe, period/high_time updated
//             stalled     - no rising edge within 2^CTR_SIZE-1 cycles
//             level       - synchronised input level
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CTR_SIZE = c_CTR_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [CTR_SIZE-1:0] period,
    output logic [CTR_SIZE-1:0] high_time,
    output logic                new_measure,
    output logic                stalled,
    output logic                level
);

    localparam logic [CTR_SIZE-1:0] c_CNT_LIMIT = {CTR_SIZE{1'b1}};
    localparam logic [CTR_SIZE-1:0] c_CNT_ONE   = {{(CTR_SIZE-1){1'b0}}, 1'b1};

    logic                 w_level;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_cnt_sat;

    logic [c_STATE_W-1:0] r_state;
    logic [CTR_SIZE-1:0]  r_cnt;
    logic [CTR_SIZE-1:0]  r_hi_latch;
    logic [CTR_SIZE-1:0]  r_period;
    logic [CTR_SIZE-1:0]  r_high_time;
    logic                 r_new_measure;
    logic                 r_stalled;

    edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .i_in    (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_cnt_sat = (r_cnt == c_CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_ARM;
            r_cnt         <= '0;
            r_hi_latch    <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_new_measure <= 1'b0;
            r_stalled     <= 1'b1;
        end else begin
            r_new_measure <= 1'b0;
            case (r_state)
                c_ST_ARM: begin
                    // Counter idles here; the first rise only starts a cycle,
                    // there is no complete cycle to report yet.
                    if (w_rise) begin
                        r_state    <= c_ST_RUN;
                        r_cnt      <= c_CNT_ONE;
                        r_hi_latch <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_rise) begin
                        // A rise on the saturation cycle still wins over the
                        // timeout. hi_latch stays 0 if no fall was seen.
                        r_period      <= r_cnt;
                        r_high_time   <= r_hi_latch;
                        r_new_measure <= 1'b1;
                        r_stalled     <= 1'b0;
                        r_cnt         <= c_CNT_ONE;
                        r_hi_latch    <= '0;
                    end else if (w_cnt_sat) begin
                        r_period    <= '0;
                        r_high_time <= '0;
                        r_stalled   <= 1'b1;
                        r_state     <= c_ST_ARM;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_fall) begin
                            r_hi_latch <= r_cnt;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_ARM;
                end
            endcase
        end
    end

    assign period      = r_period;
    assign high_time   = r_high_time;
    assign new_measure = r_new_measure;
    assign stalled     = r_stalled;
    assign level       = w_level;

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Self-checking bench for pwm_capture. Two instances (24-bit and
//             8-bit counters) share one input. A timestamp-based reference
//             model predicts every output on every cycle; table-driven
//             waveform segments and hand-written sequences add checks on the
//             values the waveform itself dictates.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int W0 = 24;
    localparam int W1 = 8;
    localparam int HIST = 131072;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;

    logic [W0-1:0] per0, hi0;
    logic          nm0, st0, lv0;
    logic [W1-1:0] per1, hi1;
    logic          nm1, st1, lv1;

    pwm_capture #(.CTR_SIZE(W0)) u_dut24 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .period(per0), .high_time(hi0), .new_measure(nm0),
        .stalled(st0), .level(lv0)
    );

    pwm_capture #(.CTR_SIZE(W1)) u_dut8 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .period(per1), .high_time(hi1), .new_measure(nm1),
        .stalled(st1), .level(lv1)
    );

    always #10 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int last_rst = -1;
    bit pin_drv [0:HIST-1];
    bit rst_drv [0:HIST-1];
    int strobes [2];

    // ---------------- reference model state ----------------
    // Works on edge timestamps: an input edge driven in cycle d becomes
    // visible at sample d+3; period = distance between rising timestamps,
    // high time = distance from rising to falling timestamp.
    int maxv  [2];
    bit m_run [2];
    int m_trise [2];
    int m_lat [2];
    int m_per [2];
    int m_hi  [2];
    bit m_nm  [2];
    bit m_st  [2];

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_per;
        int exp_hi;
        int exp_nm;
    } seg_t;
    seg_t tbl [4];

    // Input level as seen by the edge detector for sample c (cleared by reset).
    function automatic bit eff(input int c);
        if (c < 3 || (c - 3) <= last_rst) return 1'b0;
        return pin_drv[c - 3];
    endfunction

    function automatic bit exp_level(input int c);
        if (c < 2 || (c - 2) <= last_rst) return 1'b0;
        return pin_drv[c - 2];
    endfunction

    task automatic model_step(input int c);
        bit rise;
        bit fall;
        rise = eff(c) & ~eff(c - 1);
        fall = ~eff(c) & eff(c - 1);
        for (int k = 0; k < 2; k++) begin
            m_nm[k] = 1'b0;
            if (rst_drv[c - 1]) begin
                m_run[k] = 1'b0; m_per[k] = 0; m_hi[k] = 0;
                m_st[k]  = 1'b1; m_lat[k] = 0; m_trise[k] = 0;
            end else if (m_run[k] && !rise && (c - m_trise[k]) == maxv[k]) begin
                m_run[k] = 1'b0; m_per[k] = 0; m_hi[k] = 0; m_st[k] = 1'b1;
            end else if (rise) begin
                if (m_run[k]) begin
                    m_nm[k]  = 1'b1;
                    m_per[k] = c - m_trise[k];
                    m_hi[k]  = m_lat[k];
                    m_st[k]  = 1'b0;
                end
                m_run[k] = 1'b1; m_trise[k] = c; m_lat[k] = 0;
            end else if (fall && m_run[k]) begin
                m_lat[k] = c - m_trise[k];
            end
        end
    endtask

    task automatic chk_dut(input int k, input int c, input int per, input int hi,
                           input bit nm, input bit st, input bit lv, input bit elv);
        n_checks++;
        if (nm) strobes[k]++;
        if (per != m_per[k] || hi != m_hi[k] || nm != m_nm[k] || st != m_st[k] || lv != elv) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL model_dut%0d cyc=%0d got per=%0d hi=%0d nm=%0d st=%0d lv=%0d required per=%0d hi=%0d nm=%0d st=%0d lv=%0d",
                         k, c, per, hi, nm, st, lv, m_per[k], m_hi[k], m_nm[k], m_st[k], elv);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Record this cycle's drive, advance to the next sample point, check.
    task automatic tick();
        bit elv;
        pin_drv[cyc] = pwm_in;
        rst_drv[cyc] = rst;
        if (rst) last_rst = cyc;
        @(negedge clk);
        cyc++;
        model_step(cyc);
        elv = exp_level(cyc);
        chk_dut(0, cyc, int'(per0), int'(hi0), nm0, st0, lv0, elv);
        chk_dut(1, cyc, int'(per1), int'(hi1), nm1, st1, lv1, elv);
    endtask

    task automatic run_seg(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            pwm_in = 1'b1;
            repeat (hi) tick();
            pwm_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        int s0;
        int s1;
        maxv[0] = (1 << W0) - 1;
        maxv[1] = (1 << W1) - 1;
        strobes[0] = 0;
        strobes[1] = 0;

        tbl[0] = '{2048,  2048,  5, 4096,  2048, 4};
        tbl[1] = '{4096,  12288, 2, 16384, 4096, 2};
        tbl[2] = '{1,     99,    5, 100,   1,    5};
        tbl[3] = '{25,    25,    6, 50,    25,   6};

        // ---------------- reset ----------------
        rst = 1'b1; pwm_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("reset_period",    int'(per0), 0);
        check_eq("reset_high_time", int'(hi0),  0);
        check_eq("reset_strobe",    int'(nm0),  0);
        check_eq("reset_stalled",   int'(st0),  1);
        check_eq("reset_level",     int'(lv0),  0);

        // ---------------- table-driven waveform segments (24-bit) ----------------
        for (int i = 0; i < 4; i++) begin
            s0 = strobes[0];
            run_seg(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            check_eq($sformatf("seg%0d_period", i),    int'(per0), tbl[i].exp_per);
            check_eq($sformatf("seg%0d_high_time", i), int'(hi0),  tbl[i].exp_hi);
            check_eq($sformatf("seg%0d_strobes", i),   strobes[0] - s0, tbl[i].exp_nm);
            check_eq($sformatf("seg%0d_stalled", i),   int'(st0),  0);
        end
        check_eq("p50_dut8_period", int'(per1), 50);

        // ---------------- stall on 8-bit instance ----------------
        s1 = strobes[1];
        pwm_in = 1'b0;
        repeat (300) tick();
        check_eq("stall8_stalled",   int'(st1), 1);
        check_eq("stall8_period",    int'(per1), 0);
        check_eq("stall8_high_time", int'(hi1), 0);
        check_eq("stall8_strobes",   strobes[1] - s1, 0);
        run_seg(25, 25, 1);
        check_eq("rearm8_first_rise_stalled", int'(st1), 1);
        check_eq("rearm8_first_rise_strobes", strobes[1] - s1, 0);
        run_seg(25, 25, 2);
        check_eq("rearm8_stalled",   int'(st1), 0);
        check_eq("rearm8_period",    int'(per1), 50);
        check_eq("rearm8_high_time", int'(hi1), 25);

        // Period equal to the saturation value: rise beats timeout.
        s1 = strobes[1];
        run_seg(100, 155, 3);
        check_eq("sat8_period",    int'(per1), 255);
        check_eq("sat8_high_time", int'(hi1), 100);
        check_eq("sat8_stalled",   int'(st1), 0);
        check_eq("sat8_strobes",   strobes[1] - s1, 3);
        // One cycle longer: timeout first, so only the boundary cycle strobes.
        s1 = strobes[1];
        run_seg(100, 156, 3);
        check_eq("over8_strobes", strobes[1] - s1, 1);

        // ---------------- randomized segments ----------------
        for (int i = 0; i < 12; i++) begin
            run_seg(int'($urandom_range(1, 60)), int'($urandom_range(1, 200)),
                    int'($urandom_range(1, 3)));
        end

        // ---------------- input held high from reset ----------------
        rst = 1'b1; pwm_in = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("const_hi_level",   int'(lv0), 1);
        check_eq("const_hi_stalled", int'(st0), 1);
        s0 = strobes[0];
        s1 = strobes[1];
        repeat (600) tick();
        check_eq("const_hi_strobes24", strobes[0] - s0, 0);
        check_eq("const_hi_strobes8",  strobes[1] - s1, 0);
        check_eq("const_hi_stalled_end", int'(st0), 1);

        // ---------------- reset during the high phase ----------------
        pwm_in = 1'b0;
        repeat (10) tick();
        run_seg(2048, 2048, 1);
        pwm_in = 1'b1;
        repeat (1000) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_period",    int'(per0), 0);
        check_eq("midrst_high_time", int'(hi0),  0);
        check_eq("midrst_strobe",    int'(nm0),  0);
        check_eq("midrst_stalled",   int'(st0),  1);
        check_eq("midrst_level",     int'(lv0),  0);
        s0 = strobes[0];
        repeat (1048) tick();
        pwm_in = 1'b0;
        repeat (2048) tick();
        run_seg(2048, 2048, 2);
        pwm_in = 1'b1;
        repeat (4) tick();
        check_eq("postrst_period",    int'(per0), 4096);
        check_eq("postrst_high_time", int'(hi0),  2048);
        check_eq("postrst_stalled",   int'(st0),  0);
        check_eq("postrst_strobes",   strobes[0] - s0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pwm_capture
`default_nettype wire
